// File: rtl/btn_pkg.sv
// Shared types, timing defaults and width helpers for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } ch_state_e;

  localparam int DEF_DB_CYCLES     = 16;
  localparam int DEF_REPEAT_DELAY  = 1000;
  localparam int DEF_REPEAT_PERIOD = 200;

  // Ceiling log2 with a floor of one bit, so every counter has at least one flop.
  function automatic int btn_clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic int btn_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, press/release FSM.
// Optional hold auto-repeat is compiled in with BTN_AUTOREPEAT_EN.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_level,
  output logic btn_trig,
  output logic btn_rel,
  output logic btn_repeat
);

  localparam int CNT_W = btn_clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             trig_q;
  logic             trig_d;
  logic             rel_q;
  logic             rel_d;
  logic             press_acc;
  logic             rel_acc;
  ch_state_e        state_q;
  ch_state_e        state_d;

  // The counter only advances while the synchronised input disagrees with the
  // accepted level, and the level flips on its last count, so it never wraps.
  always_comb begin
    cnt_d     = '0;
    level_d   = level_q;
    press_acc = 1'b0;
    rel_acc   = 1'b0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d   = s2_q;
        press_acc = s2_q;
        rel_acc   = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int HOLD_W = btn_clog2(btn_max(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic              rpt_q;
  logic              rpt_d;

  // A release always wins over a repeat that falls due on the same edge.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    trig_d  = 1'b0;
    rpt_d   = 1'b0;
    rel_d   = rel_acc;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (press_acc) begin
          state_d = HELD;
          trig_d  = 1'b1;
        end
      end
      HELD: begin
        if (rel_acc) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (hold_q == DELAY_LAST) begin
          state_d = REPEAT;
          trig_d  = 1'b1;
          rpt_d   = 1'b1;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      REPEAT: begin
        if (rel_acc) begin
          state_d = IDLE;
          hold_d  = '0;
        end else if (hold_q == PERIOD_LAST) begin
          trig_d = 1'b1;
          rpt_d  = 1'b1;
          hold_d = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  assign btn_repeat = rpt_q;
`else
  always_comb begin
    state_d = state_q;
    trig_d  = 1'b0;
    rel_d   = rel_acc;
    case (state_q)
      IDLE: begin
        if (press_acc) begin
          state_d = HELD;
          trig_d  = 1'b1;
        end
      end
      HELD: begin
        if (rel_acc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign btn_repeat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      trig_q  <= 1'b0;
      rel_q   <= 1'b0;
      state_q <= IDLE;
`ifdef BTN_AUTOREPEAT_EN
      hold_q  <= '0;
      rpt_q   <= 1'b0;
`endif
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      trig_q  <= trig_d;
      rel_q   <= rel_d;
      state_q <= state_d;
`ifdef BTN_AUTOREPEAT_EN
      hold_q  <= hold_d;
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign btn_level = level_q;
  assign btn_trig  = trig_q;
  assign btn_rel   = rel_q;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end; each bit is an independent btn_channel.
// Hold auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_trig,
  output logic [WIDTH-1:0] btn_rel,
  output logic [WIDTH-1:0] btn_repeat
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    btn_channel #(
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_channel (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn[i]),
      .btn_level  (btn_level[i]),
      .btn_trig   (btn_trig[i]),
      .btn_rel    (btn_rel[i]),
      .btn_repeat (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: reset, debounce, glitches, multi-channel,
// reset mid-press and hold behaviour (with or without BTN_AUTOREPEAT_EN).
module tb_btn_conditioner;

  localparam int W  = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] btn;
  logic [W-1:0] btn_level;
  logic [W-1:0] btn_trig;
  logic [W-1:0] btn_rel;
  logic [W-1:0] btn_repeat;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .WIDTH         (W),
    .DB_CYCLES     (DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .btn_level  (btn_level),
    .btn_trig   (btn_trig),
    .btn_rel    (btn_rel),
    .btn_repeat (btn_repeat)
  );

  // Advance past n rising edges and settle 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  initial begin
    int trig_count;
    logic [W-1:0] exp_trig;
    logic [W-1:0] exp_rpt;
    logic [W-1:0] exp_rel;

    rst = 1'b1;
    btn = '0;
    tick(3);
    check("rst_level", btn_level, 4'b0000);
    check("rst_trig", btn_trig, 4'b0000);
    check("rst_rel", btn_rel, 4'b0000);
    check("rst_repeat", btn_repeat, 4'b0000);
    rst = 1'b0;
    tick(1);

    // Basic press on channel 0: trig with level on edge DB+2.
    btn = 4'b0001;
    for (int e = 1; e <= DB + 1; e++) begin
      tick(1);
      check("press_early_trig", btn_trig, 4'b0000);
      check("press_early_level", btn_level, 4'b0000);
    end
    tick(1);
    check("press_level", btn_level, 4'b0001);
    check("press_trig", btn_trig, 4'b0001);
    check("press_rel", btn_rel, 4'b0000);
    tick(1);
    check("press_trig_one_shot", btn_trig, 4'b0000);
    check("press_level_hold", btn_level, 4'b0001);
    btn = 4'b0000;
    tick(DB + 1);
    check("release_early_rel", btn_rel, 4'b0000);
    check("release_early_level", btn_level, 4'b0001);
    tick(1);
    check("release_rel", btn_rel, 4'b0001);
    check("release_level", btn_level, 4'b0000);
    check("release_trig", btn_trig, 4'b0000);
    tick(1);
    check("release_rel_one_shot", btn_rel, 4'b0000);

    // Glitch of DB-1 samples must be ignored.
    btn = 4'b0001;
    tick(DB - 1);
    btn = 4'b0000;
    for (int e = 0; e < 10; e++) begin
      tick(1);
      check("glitch_level", btn_level, 4'b0000);
      check("glitch_trig", btn_trig, 4'b0000);
      check("glitch_rel", btn_rel, 4'b0000);
    end

    // Bounce 1,0,1,1,...: one trig, DB+2 edges after the last rising transition.
    btn = 4'b0001;
    tick(1);
    btn = 4'b0000;
    tick(1);
    btn = 4'b0001;
    for (int e = 1; e <= DB + 1; e++) begin
      tick(1);
      check("bounce_early_trig", btn_trig, 4'b0000);
    end
    tick(1);
    check("bounce_trig", btn_trig, 4'b0001);
    check("bounce_level", btn_level, 4'b0001);
    btn = 4'b0000;
    tick(DB + 2);
    check("bounce_rel", btn_rel, 4'b0001);
    tick(2);

    // Two channels pressed together pulse together.
    btn = 4'b0101;
    tick(DB + 1);
    check("multi_early_trig", btn_trig, 4'b0000);
    tick(1);
    check("multi_trig", btn_trig, 4'b0101);
    check("multi_level", btn_level, 4'b0101);
    tick(1);
    check("multi_trig_one_shot", btn_trig, 4'b0000);
    btn = 4'b0000;
    tick(DB + 2);
    check("multi_rel", btn_rel, 4'b0101);
    check("multi_rel_level", btn_level, 4'b0000);

    // Channel 2 alone.
    btn = 4'b0100;
    tick(DB + 2);
    check("ch2_trig", btn_trig, 4'b0100);
    check("ch2_level", btn_level, 4'b0100);
    check("ch2_rel_quiet", btn_rel, 4'b0000);
    btn = 4'b0000;
    tick(DB + 2);
    check("ch2_rel", btn_rel, 4'b0100);
    check("ch2_rel_trig", btn_trig, 4'b0000);
    tick(2);

    // Reset two cycles after a trig while the button stays held.
    btn = 4'b0001;
    tick(DB + 2);
    check("rstmid_first_trig", btn_trig, 4'b0001);
    tick(2);
    rst = 1'b1;
    tick(2);
    check("rstmid_level", btn_level, 4'b0000);
    check("rstmid_trig", btn_trig, 4'b0000);
    check("rstmid_rel", btn_rel, 4'b0000);
    check("rstmid_repeat", btn_repeat, 4'b0000);
    rst = 1'b0;
    for (int e = 1; e <= DB + 1; e++) begin
      tick(1);
      check("rstmid_early_trig", btn_trig, 4'b0000);
      check("rstmid_no_rel", btn_rel, 4'b0000);
    end
    tick(1);
    check("rstmid_new_trig", btn_trig, 4'b0001);
    check("rstmid_new_level", btn_level, 4'b0001);
    btn = 4'b0000;
    tick(DB + 2);
    check("rstmid_release", btn_rel, 4'b0001);
    tick(2);

    // Long hold: initial trig at T, then the build decides whether repeats follow.
    btn = 4'b0001;
    tick(DB + 2);
    check("hold_trig_T", btn_trig, 4'b0001);
    check("hold_repeat_T", btn_repeat, 4'b0000);
    trig_count = 1;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      exp_trig = 4'b0000;
      exp_rpt  = 4'b0000;
      exp_rel  = (k == 30 + DB + 2) ? 4'b0001 : 4'b0000;
`ifdef BTN_AUTOREPEAT_EN
      if (k >= RD && ((k - RD) % RP) == 0 && k < 30 + DB + 2) begin
        exp_trig = 4'b0001;
        exp_rpt  = 4'b0001;
      end
`endif
      check($sformatf("hold_trig_T+%0d", k), btn_trig, exp_trig);
      check($sformatf("hold_repeat_T+%0d", k), btn_repeat, exp_rpt);
      check($sformatf("hold_rel_T+%0d", k), btn_rel, exp_rel);
      if (btn_trig[0]) trig_count++;
      if (k == 30) btn = 4'b0000;
    end
`ifdef BTN_AUTOREPEAT_EN
    check("hold_trig_count", 4'(trig_count), 4'd8);
`else
    check("hold_trig_count", 4'(trig_count), 4'd1);
`endif
    check("hold_final_level", btn_level, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
